br_predictor: RTL

- Fetch-stage branch predictor that sits directly upstream of the PC register.
- Looks up a table of 2-bit saturating counters indexed by the fetch PC and decodes the fetched instruction to produce the take-branch signal and the predicted or JAL target.
- Trains on branch resolution from EX. Flags mispredictions and supplies the restore address used to redirect the PC.
- Keeps 32-bit branch and mispredict performance counters.

---
 rtl/br_predictor_pkg.sv | 31 +++
 rtl/br_target_gen.sv | 28 ++
 rtl/br_predictor.sv | 85 ++++++++
 3 files changed

// File: rtl/br_predictor_pkg.sv
// Shared definitions for the fetch-stage branch predictor.
// Opcodes, 2-bit counter encodings and the saturating-counter update rule.
// No logic state lives here.
package br_predictor_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Prediction is the counter MSB: the upper two states predict taken.
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  // Step one state towards the resolved outcome, sticking at either end.
  function automatic ctr_e sat_update(input ctr_e ctr, input logic taken);
    ctr_e nxt;
    nxt = ctr;
    case (ctr)
      CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
      default: nxt = ctr;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/br_target_gen.sv
// Jump/branch target generator: fetch PC plus J-imm (JAL) or B-imm (anything else).
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
module br_target_gen
  import br_predictor_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [31:0] i_inst,
  output logic [31:0] o_target
);

  logic        w_is_jal;
  logic [31:0] w_imm_j;
  logic [31:0] w_imm_b;

  assign w_is_jal = (i_inst[6:0] == OPC_JAL);

  // Sign-extended immediates; non-JAL encodings always take the B-imm path so
  // the output stays deterministic for instructions that are not branches.
  assign w_imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                    i_inst[30:21], 1'b0};
  assign w_imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                    i_inst[11:8], 1'b0};

  // Plain 32-bit add, wraps silently.
  assign o_target = i_pc + (w_is_jal ? w_imm_j : w_imm_b);

endmodule

// File: rtl/br_predictor.sv
// Bimodal branch predictor: 2-bit counter table, target generation, EX training, perf counters.
// Latency: lookup/mispredict/restore are combinational; table and counters update on the next edge.
// Backpressure: none; the pipeline holds ex_valid low while stalled so nothing is double-trained.
module br_predictor
  import br_predictor_pkg::*;
#(
  parameter int   ENTRIES  = 64,
  parameter ctr_e CTR_INIT = CTR_WNT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  output logic        br_pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_target,
  output logic        mispredict,
  output logic [31:0] restore_addr,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);

  ctr_e             r_bht [ENTRIES];
  logic [31:0]      r_branch_cnt;
  logic [31:0]      r_mispredict_cnt;

  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_uidx;
  logic             w_is_b;
  logic             w_res;
  logic             w_mispredict;

  // Untagged index: PCs differing only above the index bits share an entry.
  assign w_idx  = if_pc[IDX_W+1:2];
  assign w_uidx = ex_pc[IDX_W+1:2];
  assign w_is_b = (if_inst[6:0] == OPC_BRANCH);

  // Lookup reads the registered table directly, so a same-cycle update at the
  // same index is only seen on the following cycle.
  assign br_pred_taken = w_is_b & r_bht[w_idx][1];

  br_target_gen u_target_gen (
    .i_pc     (if_pc),
    .i_inst   (if_inst),
    .o_target (pred_target)
  );

  assign w_res        = ex_valid & ex_is_branch;
  assign w_mispredict = w_res & (ex_taken != ex_pred_taken);
  assign mispredict   = w_mispredict;
  assign restore_addr = (w_res & ex_taken) ? ex_target : (ex_pc + 32'd4);

  // Train the counter of each resolved branch; reset returns the whole table to CTR_INIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_bht[i] <= CTR_INIT;
      end
    end else if (w_res) begin
      r_bht[w_uidx] <= sat_update(r_bht[w_uidx], ex_taken);
    end
  end

  // Free-running 32-bit perf counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      if (w_res)        r_branch_cnt     <= r_branch_cnt + 32'd1;
      if (w_mispredict) r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
    end
  end

  assign branch_cnt     = r_branch_cnt;
  assign mispredict_cnt = r_mispredict_cnt;

endmodule
